// File: rtl/slave_control.sv
// Receiving end of the chip-to-chip request/ack/valid handshake.
// Lights a notice LED for a fixed period after a request, then raises ack.
// It captures the data word on valid, or aborts with a timeout pulse, and
// waits for the master to release before it returns to idle.
module slave_control #(
  parameter int unsigned DATA_W         = 3,
  parameter int unsigned NOTICE_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 300_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  output logic              notice,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              timeout
);

  localparam int unsigned CntMax = (NOTICE_CYCLES > TIMEOUT_CYCLES) ? NOTICE_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] NoticeLoad  = CntW'(NOTICE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StNotice = 2'd1,
    StAck    = 2'd2,
    StDone   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              notice_q, notice_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              timeout_q, timeout_d;

  // Two-flop synchronizers for the cross-chip inputs
  logic              req_s1_q, req_s_q;
  logic              valid_s1_q, valid_s_q;
  logic [DATA_W-1:0] data_s1_q, data_s_q;

  // Synchronizer chains; cleared by reset so a held request is re-seen from scratch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_s1_q   <= 1'b0;
      req_s_q    <= 1'b0;
      valid_s1_q <= 1'b0;
      valid_s_q  <= 1'b0;
      data_s1_q  <= '0;
      data_s_q   <= '0;
    end else begin
      req_s1_q   <= request;
      req_s_q    <= req_s1_q;
      valid_s1_q <= valid;
      valid_s_q  <= valid_s1_q;
      data_s1_q  <= data;
      data_s_q   <= data_s1_q;
    end
  end

  // Next state, counter and registered outputs; the outputs reflect the state being entered
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ack_d        = 1'b0;
    notice_d     = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_s_q) begin
          state_d  = StNotice;
          cnt_d    = NoticeLoad;
          notice_d = 1'b1;
        end
      end
      StNotice: begin
        // A request that drops here is ignored; the master holds it until ack
        if (cnt_q == '0) begin
          state_d = StAck;
          cnt_d   = TimeoutLoad;
          ack_d   = 1'b1;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          notice_d = 1'b1;
        end
      end
      StAck: begin
        // Capture takes priority over a timeout that expires in the same cycle
        if (valid_s_q) begin
          state_d      = StDone;
          data_out_d   = data_s_q;
          data_valid_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          ack_d = 1'b1;
        end
      end
      StDone: begin
        if (!valid_s_q && !req_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d    = StIdle;
        cnt_d      = '0;
        data_out_d = '0;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      notice_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      notice_q     <= notice_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign ack        = ack_q;
  assign notice     = notice_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign timeout    = timeout_q;

endmodule
